// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Byte-stream boot loader. It receives a framed little-endian program image,
// writes each assembled 32-bit word to the shared imem/dmem write port at
// consecutive word addresses, checks an XOR checksum over the data bytes,
// and holds the CPU in reset until the image has been verified.
//
// Frame: MAGIC, count[7:0], count[15:8], count x 4 data bytes (LSB first),
//        one checksum byte (XOR of all data bytes).
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, returns to IDLE
//   rx_valid   byte on rx_data is valid
//   rx_data    incoming byte
//   rx_ready   loader accepts a byte this cycle
//   mem_write  one-cycle write strobe
//   mem_addr   word-aligned byte address of the write
//   mem_wdata  word to write
//   cpu_reset  high until the image is verified
//   done       image loaded and checksum good (sticky)
//   error      length overflow or checksum mismatch (sticky)
//
// State          | meaning
// ---------------+--------------------------------------------------------
// S_IDLE         | hunting for MAGIC, other bytes discarded
// S_COUNT_LO     | expecting low byte of word count
// S_COUNT_HI     | expecting high byte of word count, length checked here
// S_DATA         | receiving data bytes, one write per four bytes
// S_CHECK        | expecting checksum byte
// S_DONE         | image verified, CPU released, input ignored
// S_ERROR        | overflow or bad checksum, left only by reset
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int unsigned DEPTH_WORDS = 1048576,
    parameter logic [7:0]  MAGIC       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT_LO,
        S_COUNT_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]  count_lo;
    logic [15:0] count;
    logic [20:0] index;
    logic [1:0]  lane;
    logic [23:0] asm_buf;
    logic [7:0]  acc;

    logic        accept;
    logic [15:0] count_rx;
    logic [20:0] index_inc;
    logic        last_word;
    logic        overflow;

    // rx_ready depends only on state, so the handshake has no comb loop.
    assign rx_ready  = (state != S_DONE) && (state != S_ERROR);
    assign accept    = rx_valid & rx_ready;
    assign count_rx  = {rx_data, count_lo};
    assign index_inc = index + 21'd1;
    assign last_word = (index_inc == {5'd0, count});
    assign overflow  = ({16'd0, count_rx} > 32'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && (rx_data == MAGIC)) begin
                    state_next = S_COUNT_LO;
                end
            end
            S_COUNT_LO: begin
                if (accept) begin
                    state_next = S_COUNT_HI;
                end
            end
            S_COUNT_HI: begin
                if (accept) begin
                    if (overflow) begin
                        state_next = S_ERROR;
                    end else if (count_rx == 16'd0) begin
                        state_next = S_CHECK;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (lane == 2'd3) && last_word) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_next = (rx_data == acc) ? S_DONE : S_ERROR;
                end
            end
            S_DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_write <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            count_lo  <= 8'd0;
            count     <= 16'd0;
            index     <= 21'd0;
            lane      <= 2'd0;
            asm_buf   <= 24'd0;
            acc       <= 8'd0;
        end else begin
            mem_write <= 1'b0;
            if (accept) begin
                case (state)
                    S_COUNT_LO: begin
                        count_lo <= rx_data;
                    end
                    S_COUNT_HI: begin
                        count <= count_rx;
                        index <= 21'd0;
                        lane  <= 2'd0;
                        acc   <= 8'd0;
                    end
                    S_DATA: begin
                        acc  <= acc ^ rx_data;
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: asm_buf[7:0]   <= rx_data;
                            2'd1: asm_buf[15:8]  <= rx_data;
                            2'd2: asm_buf[23:16] <= rx_data;
                            default: begin
                                // Last byte of the word bypasses the buffer
                                // so the write issues with no extra cycle.
                                mem_write <= 1'b1;
                                mem_addr  <= {9'd0, index, 2'b00};
                                mem_wdata <= {rx_data, asm_buf};
                                index     <= index_inc;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;

    logic        rx_ready, mem_write, cpu_reset, done, error;
    logic [31:0] mem_addr, mem_wdata;

    logic        s_rx_ready, s_mem_write, s_cpu_reset, s_done, s_error;
    logic [31:0] s_mem_addr, s_mem_wdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          s_wr_cnt = 0;
    logic [31:0] words[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    program_loader #(.DEPTH_WORDS(4)) dut_small (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(s_rx_ready), .mem_write(s_mem_write), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .cpu_reset(s_cpu_reset), .done(s_done), .error(s_error)
    );

    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (s_mem_write === 1'b1) s_wr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Presents one byte for one cycle; dropped if the loader is not ready.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Sends a frame built from 'words' and checks writes and final status
    // against the frame's own content.
    task automatic run_frame(input string tag, input bit gaps, input bit bad, input bit resync);
        int          n;
        int          base;
        logic [7:0]  sum;
        logic [7:0]  b;
        n    = words.size();
        base = wr_addr_q.size();
        sum  = 8'd0;
        if (resync) begin
            send_byte(8'h00, gaps);
            send_byte(8'hFF, gaps);
            send_byte(8'($urandom) & 8'h7F, gaps);
        end
        send_byte(8'hA5, gaps);
        send_byte(8'(n), gaps);
        send_byte(8'(n >> 8), gaps);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b   = 8'(words[w] >> (8 * k));
                sum = sum ^ b;
                send_byte(b, gaps);
            end
            chk({tag, " strobe"}, {31'd0, mem_write}, 32'd1);
            chk({tag, " addr"}, mem_addr, 32'(w * 4));
            chk({tag, " wdata"}, mem_wdata, words[w]);
        end
        send_byte(bad ? ~sum : sum, gaps);
        chk({tag, " done"}, {31'd0, done}, {31'd0, !bad});
        chk({tag, " error"}, {31'd0, error}, {31'd0, bad});
        chk({tag, " cpu_reset"}, {31'd0, cpu_reset}, {31'd0, bad});
        chk({tag, " rx_ready"}, {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        chk({tag, " nwrites"}, 32'(wr_addr_q.size() - base), 32'(n));
        if (wr_addr_q.size() - base == n) begin
            for (int w = 0; w < n; w++) begin
                chk({tag, " log addr"}, wr_addr_q[base + w], 32'(w * 4));
                chk({tag, " log data"}, wr_data_q[base + w], words[w]);
            end
        end
    endtask

    initial begin
        int base;
        int sbase;
        int n;
        bit bad;

        @(negedge clk);
        do_reset();
        chk("rst rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst error", {31'd0, error}, 32'd0);

        // Nominal, back-to-back bytes
        words = '{32'hE3A00007, 32'hE5800064};
        run_frame("nominal", 1'b0, 1'b0, 1'b0);
        base = wr_addr_q.size();
        for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b0);
        @(negedge clk);
        chk("done ignores input", 32'(wr_addr_q.size() - base), 32'd0);
        chk("done sticky", {31'd0, done}, 32'd1);

        do_reset();
        chk("reset clears done", {31'd0, done}, 32'd0);
        chk("reset cpu_reset", {31'd0, cpu_reset}, 32'd1);
        run_frame("badsum", 1'b0, 1'b1, 1'b0);

        do_reset();
        chk("reset clears error", {31'd0, error}, 32'd0);
        run_frame("resync", 1'b1, 1'b0, 1'b1);

        // Zero-length frames
        do_reset();
        words = {};
        run_frame("zero ok", 1'b0, 1'b0, 1'b0);
        do_reset();
        run_frame("zero bad", 1'b1, 1'b1, 1'b0);

        // Overflow on the 4-word instance: count 5
        do_reset();
        sbase = s_wr_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("ovf error", {31'd0, s_error}, 32'd1);
        chk("ovf rx_ready", {31'd0, s_rx_ready}, 32'd0);
        chk("ovf cpu_reset", {31'd0, s_cpu_reset}, 32'd1);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
        @(negedge clk);
        chk("ovf no write", 32'(s_wr_cnt - sbase), 32'd0);
        chk("ovf done", {31'd0, s_done}, 32'd0);

        // Count equal to capacity is legal on the 4-word instance
        do_reset();
        sbase = s_wr_cnt;
        words = {};
        for (int i = 0; i < 4; i++) words.push_back($urandom);
        run_frame("full", 1'b1, 1'b0, 1'b0);
        chk("full small done", {31'd0, s_done}, 32'd1);
        chk("full small writes", 32'(s_wr_cnt - sbase), 32'd4);

        // Reset in the middle of word 0
        do_reset();
        base = wr_addr_q.size();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h00, 1'b0);
        do_reset();
        chk("abort no write", 32'(wr_addr_q.size() - base), 32'd0);
        chk("abort rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("abort cpu_reset", {31'd0, cpu_reset}, 32'd1);
        words = '{32'hE3A00007, 32'hE5800064};
        run_frame("after abort", 1'b0, 1'b0, 1'b0);

        // Randomized frames
        for (int r = 0; r < 6; r++) begin
            do_reset();
            n = $urandom_range(1, 6);
            bad = 1'($urandom);
            words = {};
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_frame("random", 1'b1, bad, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
